alu_issue_ctrl: RTL

Multi-cycle issue controller that sits between the datapath register file and the 2-bit-select ALU (00 pass A, 01 A+B, 10 A&B, 11 ~A). It accepts one LC-3 operate instruction (ADD, AND, NOT) per handshake and reads source operands through a single register-file read port. It then drives the ALU select and operands, writes the result back, and updates the NZP condition codes.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/nzp_logic.sv | 17 +
 rtl/alu_issue_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the LC-3 operate-instruction issue path:
// opcodes, ALU selects, controller states and the latched instruction fields.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned IMM_W  = 5;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b0101;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1001;

  localparam logic [SEL_W-1:0] SEL_PASS = 2'b00;
  localparam logic [SEL_W-1:0] SEL_ADD  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_AND  = 2'b10;
  localparam logic [SEL_W-1:0] SEL_NOT  = 2'b11;

  typedef enum logic [2:0] {IDLE, RD1, RD2, EXEC, WB, ILL} state_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             imm_mode;
    logic [REG_W-1:0] dr;
    logic [IMM_W-1:0] low5;
  } instr_t;

  // SEL_PASS doubles as the "illegal" marker: no legal operate maps to pass-A.
  function automatic logic [SEL_W-1:0] decode_sel(input logic [OP_W-1:0] op,
                                                   input logic [5:0] low6);
    logic [SEL_W-1:0] sel;
    sel = SEL_PASS;
    case (op)
      OP_ADD:  sel = SEL_ADD;
      OP_AND:  sel = SEL_AND;
      OP_NOT:  if (low6 == 6'b111111) sel = SEL_NOT;
      default: sel = SEL_PASS;
    endcase
    return sel;
  endfunction

  function automatic logic [DATA_W-1:0] sext5(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/nzp_logic.sv
// Condition-code classifier: result to {N,Z,P}. Shared with the load path.
module nzp_logic
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] result,
  output logic [2:0]        nzp_c
);

  always_comb begin
    nzp_c = 3'b001;
    if (result[DATA_W-1])
      nzp_c = 3'b100;
    else if (result == '0)
      nzp_c = 3'b010;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for LC-3 ADD/AND/NOT: reads operands through one
// register-file port, drives the ALU, writes back and updates NZP.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Instr_Valid,
  input  logic [DATA_W-1:0] IR,
  output logic              Instr_Ready,
  output logic [REG_W-1:0]  RF_RdAddr,
  input  logic [DATA_W-1:0] RF_RdData,
  output logic [SEL_W-1:0]  ALU_Sel,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  input  logic [DATA_W-1:0] ALU_Out,
  output logic              RF_WrEn,
  output logic [REG_W-1:0]  RF_WrAddr,
  output logic [DATA_W-1:0] RF_WrData,
  output logic [2:0]        NZP,
  output logic              Done,
  output logic              Illegal
);

  state_t              state, state_n;
  instr_t              instr_q, dec;
  logic [DATA_W-1:0]   a_q;
  logic                reg_mode;
  logic [DATA_W-1:0]   imm_b;
  logic [2:0]          nzp_wb;

  logic                ready_n;
  logic [REG_W-1:0]    rd_addr_n;
  logic [SEL_W-1:0]    sel_n;
  logic [DATA_W-1:0]   a_n, b_n;
  logic                wr_en_n;
  logic [REG_W-1:0]    wr_addr_n;
  logic [DATA_W-1:0]   wr_data_n;
  logic                done_n, illegal_n;

  always_comb begin
    dec          = '0;
    dec.sel      = decode_sel(IR[15:12], IR[5:0]);
    dec.imm_mode = IR[5];
    dec.dr       = IR[11:9];
    dec.low5     = IR[4:0];
  end

  assign reg_mode = (instr_q.sel != SEL_NOT) && !instr_q.imm_mode;
  assign imm_b    = (instr_q.sel == SEL_NOT) ? '0 : sext5(instr_q.low5);

  nzp_logic u_nzp (
    .result (RF_WrData),
    .nzp_c  (nzp_wb)
  );

  // Outputs are registered, so each is computed for the state being entered.
  always_comb begin
    state_n   = state;
    rd_addr_n = '0;
    sel_n     = SEL_PASS;
    a_n       = '0;
    b_n       = '0;
    wr_en_n   = 1'b0;
    wr_addr_n = '0;
    wr_data_n = '0;
    done_n    = 1'b0;
    illegal_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (Instr_Valid && Instr_Ready) begin
          if (dec.sel != SEL_PASS) begin
            state_n   = RD1;
            rd_addr_n = IR[8:6];
          end else begin
            state_n   = ILL;
            illegal_n = 1'b1;
          end
        end
      end
      RD1: begin
        if (reg_mode) begin
          state_n   = RD2;
          rd_addr_n = instr_q.low5[REG_W-1:0];
        end else begin
          state_n = EXEC;
          sel_n   = instr_q.sel;
          a_n     = RF_RdData;
          b_n     = imm_b;
        end
      end
      RD2: begin
        state_n = EXEC;
        sel_n   = instr_q.sel;
        a_n     = a_q;
        b_n     = RF_RdData;
      end
      EXEC: begin
        state_n   = WB;
        wr_en_n   = 1'b1;
        wr_addr_n = instr_q.dr;
        wr_data_n = ALU_Out;
        done_n    = 1'b1;
      end
      WB:      state_n = IDLE;
      ILL:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      instr_q     <= '0;
      a_q         <= '0;
      Instr_Ready <= 1'b1;
      RF_RdAddr   <= '0;
      ALU_Sel     <= SEL_PASS;
      ALU_A       <= '0;
      ALU_B       <= '0;
      RF_WrEn     <= 1'b0;
      RF_WrAddr   <= '0;
      RF_WrData   <= '0;
      NZP         <= 3'b010;
      Done        <= 1'b0;
      Illegal     <= 1'b0;
    end else begin
      state       <= state_n;
      Instr_Ready <= ready_n;
      RF_RdAddr   <= rd_addr_n;
      ALU_Sel     <= sel_n;
      ALU_A       <= a_n;
      ALU_B       <= b_n;
      RF_WrEn     <= wr_en_n;
      RF_WrAddr   <= wr_addr_n;
      RF_WrData   <= wr_data_n;
      Done        <= done_n;
      Illegal     <= illegal_n;
      if (state == IDLE && Instr_Valid && Instr_Ready)
        instr_q <= dec;
      if (state == RD1)
        a_q <= RF_RdData;
      // Condition codes take the retiring result at the end of writeback.
      if (state == WB)
        NZP <= nzp_wb;
    end
  end

endmodule
